// File: rtl/exu_lsu.sv
// Load/store unit: turns one EXU memory op into a single-beat bus request and a WBU writeback.
// Latency: request seen on mem_* one cycle after acceptance; load writeback one cycle after rvalid.
// Backpressure: one op in flight; req_ready_o only in IDLE, hold_flag_o stalls the pipeline meanwhile.
module exu_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        lsu_reg_we_o,
    output logic [4:0]  lsu_reg_waddr_o,
    output logic [31:0] lsu_reg_wdata_o,

    output logic        hold_flag_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic        discard;
    logic [1:0]  ld_size;
    logic [1:0]  ld_lane;
    logic        ld_unsigned;
    logic [4:0]  ld_rd;

    logic        misaligned;
    logic [3:0]  wmask_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        tmo_hit;
    logic        req_leave;

    // Request decode: alignment, byte strobes and lane replication of store data.
    always_comb begin
        misaligned = 1'b0;
        wmask_nxt  = 4'b1111;
        wdata_nxt  = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                wmask_nxt = 4'b0001 << req_addr_i[1:0];
                wdata_nxt = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = req_addr_i[0];
                wmask_nxt  = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_nxt  = {2{req_wdata_i[15:0]}};
            end
            default: misaligned = |req_addr_i[1:0];
        endcase
        if (!req_we_i) begin
            wmask_nxt = 4'b0000;
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (ld_lane)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = ld_lane[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (ld_size)
            2'd0:    load_ext = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign tmo_hit     = (tmo_cnt + 8'd1) == TMO_LIMIT;
    assign req_leave   = mem_gnt_i | flush_i | tmo_hit;
    // Gated by rst_n so the stall request is low for the whole reset window.
    assign hold_flag_o = rst_n & ((state != IDLE) | (req_valid_i & ~misaligned & ~flush_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tmo_cnt         <= 8'd0;
            discard         <= 1'b0;
            ld_size         <= 2'd0;
            ld_lane         <= 2'd0;
            ld_unsigned     <= 1'b0;
            ld_rd           <= 5'd0;
            req_ready_o     <= 1'b1;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= 32'd0;
            mem_wdata_o     <= 32'd0;
            mem_wmask_o     <= 4'd0;
            lsu_reg_we_o    <= 1'b0;
            lsu_reg_waddr_o <= 5'd0;
            lsu_reg_wdata_o <= 32'd0;
            misalign_o      <= 1'b0;
            bus_err_o       <= 1'b0;
        end else begin
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            lsu_reg_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        if (misaligned) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state       <= REQ;
                            req_ready_o <= 1'b0;
                            tmo_cnt     <= 8'd0;
                            discard     <= 1'b0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                            mem_wdata_o <= wdata_nxt;
                            mem_wmask_o <= wmask_nxt;
                            ld_size     <= req_size_i;
                            ld_lane     <= req_addr_i[1:0];
                            ld_unsigned <= req_unsigned_i;
                            ld_rd       <= req_rd_i;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (req_leave) begin
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= 32'd0;
                        mem_wdata_o <= 32'd0;
                        mem_wmask_o <= 4'd0;
                    end
                    if (mem_gnt_i) begin
                        if (mem_we_o) begin
                            state       <= IDLE;
                            req_ready_o <= 1'b1;
                        end else begin
                            // A flush coinciding with the grant still has to drain the read.
                            state   <= WAIT;
                            tmo_cnt <= 8'd0;
                            discard <= flush_i;
                        end
                    end else if (flush_i) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                    end else if (tmo_hit) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                        bus_err_o   <= 1'b1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (flush_i) begin
                        discard <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                        if (!discard && !flush_i && ld_rd != 5'd0) begin
                            lsu_reg_we_o    <= 1'b1;
                            lsu_reg_waddr_o <= ld_rd;
                            lsu_reg_wdata_o <= load_ext;
                        end
                    end else if (tmo_hit) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                        bus_err_o   <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_lsu.sv
// Directed and randomized bench for exu_lsu against a transaction-level reference model.
module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        lsu_reg_we_o;
    logic [4:0]  lsu_reg_waddr_o;
    logic [31:0] lsu_reg_wdata_o;
    logic        hold_flag_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0]  last_mask;
    logic [31:0] last_wdata;

    exu_lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .lsu_reg_we_o(lsu_reg_we_o), .lsu_reg_waddr_o(lsu_reg_waddr_o),
        .lsu_reg_wdata_o(lsu_reg_wdata_o), .hold_flag_o(hold_flag_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: access width in bytes and the rules derived from it.
    function automatic int m_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % m_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [31:0] addr);
        int m;
        m = ((1 << m_bytes(size)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        longint v;
        longint rep;
        int n;
        n = m_bytes(size);
        v = longint'(wd) & ((64'd1 << (8 * n)) - 1);
        rep = (n == 1) ? 64'h01010101 : (n == 2) ? 64'h00010001 : 64'd1;
        v = v * rep;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic uns, input logic [31:0] rdata);
        longint v;
        int n;
        n = m_bytes(size);
        v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
        if (!uns && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl_mode: 0 none, 1 flush in REQ before grant, 2 flush during WAIT (loads).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input int fl_mode,
                           input logic [31:0] rdata);
        logic mis;
        logic wb;
        mis = m_misaligned(size, addr);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
        req_size_i = size; req_unsigned_i = uns; req_rd_i = rd;
        #1;
        chk("idle_ready", req_ready_o, 1);
        chk("hold_on_req", hold_flag_o, !mis);
        tick();
        req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
        req_size_i = 2'($urandom); req_we_i = 1'($urandom); req_rd_i = 5'($urandom);
        #1;
        if (mis) begin
            chk("misalign_pulse", misalign_o, 1);
            chk("mis_no_mem", mem_req_o, 0);
            chk("mis_ready", req_ready_o, 1);
            chk("mis_hold", hold_flag_o, 0);
            tick();
            chk("misalign_clear", misalign_o, 0);
            chk("mis_no_mem2", mem_req_o, 0);
            return;
        end
        chk("mem_req", mem_req_o, 1);
        chk("mem_we", mem_we_o, we);
        chk("mem_addr", mem_addr_o, addr & ~32'h3);
        chk("mem_wmask", mem_wmask_o, we ? m_mask(size, addr) : 4'd0);
        if (we) chk("mem_wdata", mem_wdata_o, m_wdata(size, wd));
        chk("busy_ready", req_ready_o, 0);
        chk("busy_hold", hold_flag_o, 1);
        last_mask = mem_wmask_o;
        last_wdata = mem_wdata_o;
        if (fl_mode == 1) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            chk("flush_drop_req", mem_req_o, 0);
            chk("flush_drop_ready", req_ready_o, 1);
            tick();
            chk("flush_drop_wb", lsu_reg_we_o, 0);
            return;
        end
        for (int i = 0; i < gnt_dly; i++) begin
            tick();
            chk("req_stable", mem_req_o, 1);
            chk("addr_stable", mem_addr_o, addr & ~32'h3);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("gnt_req_drop", mem_req_o, 0);
        if (we) begin
            chk("st_idle", req_ready_o, 1);
            chk("st_no_wb", lsu_reg_we_o, 0);
            return;
        end
        chk("ld_wait", req_ready_o, 0);
        for (int i = 0; i < rv_dly; i++) begin
            flush_i = (fl_mode == 2 && i == 0);
            tick();
            flush_i = 1'b0;
            chk("wait_hold", hold_flag_o, 1);
        end
        flush_i = (fl_mode == 2 && rv_dly == 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        tick();
        mem_rvalid_i = 1'b0; flush_i = 1'b0; mem_rdata_i = $urandom;
        wb = (fl_mode != 2) && (rd != 5'd0);
        chk("ld_done_ready", req_ready_o, 1);
        chk("ld_we", lsu_reg_we_o, wb);
        if (wb) begin
            chk("ld_waddr", lsu_reg_waddr_o, rd);
            chk("ld_wdata", lsu_reg_wdata_o, m_load(size, addr, uns, rdata));
        end
        tick();
        chk("we_pulse_end", lsu_reg_we_o, 0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [1:0] sz;
        logic w;
        int fm;

        rst_n = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0;
        req_wdata_i = 32'h0; req_size_i = 2'd2; req_unsigned_i = 1'b0; req_rd_i = 5'd1;
        flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_hold", hold_flag_o, 0);
        chk("rst_reg_we", lsu_reg_we_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        req_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // lb 0x1003 with byte 0x80 in lane 3
        run_txn(1'b0, 32'h1003, 32'h0, 2'd0, 1'b0, 5'd5, 0, 1, 0, 32'h80123456);
        chk("lb_mask_const", last_mask, 4'd0);
        chk("lb_wdata_const", lsu_reg_wdata_o, 32'hFFFFFF80);

        // sh 0x1234 at 0x2002
        run_txn(1'b1, 32'h2002, 32'hABCD1234, 2'd1, 1'b0, 5'd0, 2, 0, 0, 32'h0);
        chk("sh_mask_const", last_mask, 4'b1100);
        chk("sh_wdata_const", last_wdata, 32'h12341234);

        // lw at 0x3001 is misaligned
        run_txn(1'b0, 32'h3001, 32'h0, 2'd2, 1'b0, 5'd7, 0, 0, 0, 32'h0);

        // lhu 0x4000 flushed during WAIT
        run_txn(1'b0, 32'h4000, 32'h0, 2'd1, 1'b1, 5'd9, 0, 2, 2, 32'h0000FFFF);

        // Load granted but never answered
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h5000; req_size_i = 2'd2; req_rd_i = 5'd3;
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        n = 0;
        while (n < 300 && bus_err_o !== 1'b1) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_ready", req_ready_o, 1);
        chk("tmo_no_wb", lsu_reg_we_o, 0);
        tick();
        chk("tmo_pulse_end", bus_err_o, 0);

        // Reset while in WAIT
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h6000; req_size_i = 2'd2; req_rd_i = 5'd4;
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        req_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", req_ready_o, 1);
        chk("midrst_hold", hold_flag_o, 0);
        chk("midrst_mem_req", mem_req_o, 0);
        chk("midrst_wmask", mem_wmask_o, 0);
        chk("midrst_addr", mem_addr_o, 0);
        tick();
        req_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        run_txn(1'b1, 32'h7004, 32'h55AA55AA, 2'd2, 1'b0, 5'd0, 1, 0, 0, 32'h0);

        // Randomized transactions with idle rvalid noise
        for (int t = 0; t < 60; t++) begin
            mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
            tick();
            mem_rvalid_i = 1'b0;
            chk("idle_rvalid_ignored", lsu_reg_we_o, 0);
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(m_bytes(sz) - 1);
            w = 1'($urandom);
            fm = $urandom_range(0, 9);
            fm = (fm == 0) ? 1 : (fm == 1 && !w) ? 2 : 0;
            run_txn(w, a, $urandom, sz, 1'($urandom), 5'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), fm, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
